mul_div_unit: RTL and testbench
===============================

Name: mul_div_unit

Overview:
- Iterative multiply/divide unit in the EX stage of the 32-bit pipelined MIPS processor. Owns the HI/LO registers.
- Executes MULT, MULTU, DIV and DIVU as 33-cycle operations.
- Asserts busy so the hazard logic stalls any MFHI/MFLO/MTHI/MTLO or new mul/div issue until the result commits.

Parameters:
- WIDTH, 32, operand and HI/LO width. The test values below assume 32.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  issue a mul/div op; sampled only in IDLE.
- op  input  2  00=MULT, 01=MULTU, 10=DIV, 11=DIVU; sampled with start.
- rs_val  input  WIDTH  multiplicand or dividend.
- rt_val  input  WIDTH  multiplier or divisor.
- flush  input  1  abort the in-flight op (branch or exception squash).
- mthi  input  1  write wdata into HI; honoured only in IDLE.
- mtlo  input  1  write wdata into LO; honoured only in IDLE.
- wdata  input  WIDTH  MTHI/MTLO data.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.
- busy  output  1  operation in flight; the pipeline must stall dependent instructions.
- done  output  1  one-cycle pulse when HI/LO take a new result.

Behaviour:
- Reset (rst=1 at an edge): state←IDLE; hi, lo, busy, done, counter and datapath regs←0. Reset has priority over every other input, including mid-operation.
- State machine:
  - IDLE: on start, latch op and operands. For signed ops, latch operand magnitudes plus the result sign flags; counter←0; go to CALC.
  - CALC: 32 iterations, one per edge, counter 0..31. After the edge where counter=31, go to FIX.
  - FIX: apply sign correction, write hi/lo, done←1, go to IDLE.
- Timing: start sampled at edge E0; busy=1 from after E0 through after E32 (33 cycles); hi/lo update at E33; done=1 for the single cycle after E33; busy=0 after E33.
- A new start can be accepted at E33+1.
- Multiply: shift-add, 2*WIDTH-bit product. {hi,lo}=product.
  - MULT: if the operand signs differ, negate the 64-bit magnitude product.
- Divide: restoring, one quotient bit per iteration. lo=quotient, hi=remainder.
  - DIV: quotient sign = sign(rs) XOR sign(rt); remainder sign = sign(rs).
  - 0x80000000 / -1 gives lo=0x80000000, hi=0 (wraps, no trap).
- Divide by zero (rt_val=0, DIV or DIVU): run the full 33 cycles; hi=rs_val unmodified, lo=0xFFFFFFFF.
- start while busy: ignored.
- mthi/mtlo while busy: ignored. The hazard unit guarantees they are stalled.
- mthi/mtlo in IDLE without start: the selected register←wdata at that edge. mthi and mtlo together write both registers.
- start together with mthi/mtlo in IDLE: start wins and the move is dropped.
- flush:
  - in CALC or FIX: return to IDLE at that edge; hi/lo unchanged; done stays 0; busy=0 after the edge.
  - in IDLE together with start: the start is discarded.
- hi/lo change only on reset, a committed FIX, or a move in IDLE.

Test Plan:
- Reset, then MULT rs=0xFFFFFFFD (-3), rt=7 → busy high 33 cycles; done pulse at cycle 34; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- MULTU rs=rt=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. A second start pulsed at cycle 10 is ignored and the result is unchanged.
- DIV rs=0xFFFFFFF9 (-7), rt=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU rs=100, rt=0 → after 33 busy cycles, hi=0x00000064, lo=0xFFFFFFFF.
- Preload hi=0x11111111 via mthi; start DIVU 9/2; assert flush at cycle 15 → busy drops after that edge, no done pulse, hi=0x11111111, lo unchanged. mthi during busy has no effect.
- Start MULTU 5*5, assert rst at cycle 20 → hi=lo=0, busy=0 next cycle. A fresh MULTU 5*5 then gives lo=25, hi=0.

Source files
------------

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit owning the HI/LO registers.
// Shift-add multiply and restoring divide, one bit per cycle, on operand
// magnitudes; the sign is fixed up in a final cycle before HI/LO commit.
//
// state | meaning
// IDLE  | waiting for start; MTHI/MTLO moves honoured here
// CALC  | WIDTH iterations of the shift-add / restoring-divide step
// FIX   | sign correction, HI/LO write, done pulse
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             flush,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] opd_q;     // multiplicand or divisor magnitude
    logic [WIDTH-1:0] rem_q;     // product upper half or partial remainder
    logic [WIDTH-1:0] quo_q;     // multiplier / dividend, shifted into the result
    logic             is_div_q;
    logic             div0_q;
    logic             neg_lo_q;
    logic             neg_hi_q;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic             busy_q, done_q;

    logic             rs_neg, rt_neg;
    logic [WIDTH-1:0] rs_mag, rt_mag;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] rem_d, quo_d;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0] hi_d, lo_d;

    // Operand magnitudes for issue; only signed ops (op[0]=0) look at sign bits.
    always_comb begin
        rs_neg = ~op[0] & rs_val[WIDTH-1];
        rt_neg = ~op[0] & rt_val[WIDTH-1];
        rs_mag = rs_neg ? -rs_val : rs_val;
        rt_mag = rt_neg ? -rt_val : rt_val;
    end

    // One iteration of the multiply or divide step, plus the final sign fix-up.
    always_comb begin
        mul_sum = {1'b0, rem_q} + (quo_q[0] ? {1'b0, opd_q} : '0);
        trial   = {rem_q, quo_q[WIDTH-1]} - {1'b0, opd_q};
        if (!is_div_q) begin
            rem_d = mul_sum[WIDTH:1];
            quo_d = {mul_sum[0], quo_q[WIDTH-1:1]};
        end else if (!trial[WIDTH]) begin
            rem_d = trial[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_d = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end

        prod     = {rem_q, quo_q};
        prod_fix = neg_lo_q ? -prod : prod;
        if (is_div_q) begin
            // Divide by zero leaves the dividend magnitude in rem_q, so the
            // remainder sign fix restores rs exactly; only LO is forced.
            hi_d = neg_hi_q ? -rem_q : rem_q;
            lo_d = div0_q ? '1 : (neg_lo_q ? -quo_q : quo_q);
        end else begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
        end
    end

    // Sequencer, datapath registers and HI/LO.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            opd_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            is_div_q <= 1'b0;
            div0_q   <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (!flush) begin
                            is_div_q <= op[1];
                            div0_q   <= op[1] & (rt_val == '0);
                            neg_lo_q <= rs_neg ^ rt_neg;
                            neg_hi_q <= op[1] ? rs_neg : (rs_neg ^ rt_neg);
                            opd_q    <= op[1] ? rt_mag : rs_mag;
                            quo_q    <= op[1] ? rs_mag : rt_mag;
                            rem_q    <= '0;
                            cnt_q    <= '0;
                            busy_q   <= 1'b1;
                            state_q  <= CALC;
                        end
                    end else begin
                        if (mthi) hi_q <= wdata;
                        if (mtlo) lo_q <= wdata;
                    end
                end
                CALC: begin
                    if (flush) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        rem_q <= rem_d;
                        quo_q <= quo_d;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == LAST) state_q <= FIX;
                    end
                end
                FIX: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                    if (!flush) begin
                        hi_q   <= hi_d;
                        lo_q   <= lo_d;
                        done_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed-vector bench for mul_div_unit with hand-computed results.
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] rs_val = '0;
    logic [31:0] rt_val = '0;
    logic        flush = 1'b0;
    logic        mthi = 1'b0;
    logic        mtlo = 1'b0;
    logic [31:0] wdata = '0;
    logic [31:0] hi, lo;
    logic        busy, done;

    int n_cmp = 0;
    int n_err = 0;

    mul_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .rs_val(rs_val), .rt_val(rt_val), .flush(flush),
        .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
        .hi(hi), .lo(lo), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op and wait for it to commit. inj: 0 none, 1 extra start at
    // busy cycle 10, 2 mthi/mtlo at busy cycle 10. old_hi/old_lo are the
    // values HI/LO must hold while the op is in flight.
    task automatic run_op(input string tag, input logic [1:0] o,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] old_hi, input logic [31:0] old_lo,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input int inj);
        int bc;
        start = 1'b1; op = o; rs_val = a; rt_val = b;
        tick();
        start = 1'b0;
        chk({tag, "_busy_e0"}, {31'd0, busy}, 32'd1);
        bc = 0;
        while (busy === 1'b1 && bc < 100) begin
            bc++;
            if (inj != 0 && bc == 10) begin
                if (inj == 1) begin
                    start = 1'b1; op = 2'b11; rs_val = 32'd3; rt_val = 32'd1;
                end else begin
                    mthi = 1'b1; mtlo = 1'b1; wdata = 32'h2222_2222;
                end
            end else begin
                start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
            end
            if (bc == 20) begin
                chk({tag, "_hi_inflight"}, hi, old_hi);
                chk({tag, "_lo_inflight"}, lo, old_lo);
            end
            tick();
        end
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        chk({tag, "_busy_cycles"}, bc, 32'd33);
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_hi"}, hi, exp_hi);
        chk({tag, "_lo"}, lo, exp_lo);
    endtask

    initial begin
        int bc;
        tick();
        tick();
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        rst = 1'b0;
        tick();

        // -3 * 7 = -21
        run_op("mult", 2'b00, 32'hFFFF_FFFD, 32'd7, 32'h0, 32'h0,
               32'hFFFF_FFFF, 32'hFFFF_FFEB, 0);
        tick();
        chk("mult_done_pulse", {31'd0, done}, 32'd0);

        // 0xFFFFFFFF^2 = 0xFFFFFFFE_00000001, second start ignored
        run_op("multu", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               32'hFFFF_FFFF, 32'hFFFF_FFEB, 32'hFFFF_FFFE, 32'h0000_0001, 1);
        tick();
        chk("multu_no_restart", {31'd0, busy}, 32'd0);

        // -7 / 2 = -3 rem -1
        run_op("div", 2'b10, 32'hFFFF_FFF9, 32'd2,
               32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
        // back-to-back issue: most negative / -1 wraps
        run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF,
               32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h0, 32'h8000_0000, 0);
        // signed divide with negative divisor: 7 / -2 = -3 rem 1
        run_op("div_negd", 2'b10, 32'd7, 32'hFFFF_FFFE,
               32'h0, 32'h8000_0000, 32'h0000_0001, 32'hFFFF_FFFD, 0);

        // divide by zero
        run_op("divu0", 2'b11, 32'd100, 32'd0,
               32'h1, 32'hFFFF_FFFD, 32'h0000_0064, 32'hFFFF_FFFF, 0);
        run_op("div0_neg", 2'b10, 32'hFFFF_FFF9, 32'd0,
               32'h64, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 0);

        // mthi preload, then flush mid-op with a mthi attempt while busy
        mthi = 1'b1; wdata = 32'h1111_1111;
        tick();
        mthi = 1'b0;
        chk("mthi_hi", hi, 32'h1111_1111);
        chk("mthi_lo_kept", lo, 32'hFFFF_FFFF);
        start = 1'b1; op = 2'b11; rs_val = 32'd9; rt_val = 32'd2;
        tick();
        start = 1'b0;
        bc = 0;
        while (busy === 1'b1 && bc < 15) begin
            bc++;
            if (bc == 5) begin mthi = 1'b1; wdata = 32'h2222_2222; end
            else mthi = 1'b0;
            if (bc == 15) flush = 1'b1;
            tick();
        end
        flush = 1'b0; mthi = 1'b0;
        chk("flush_reached", bc, 32'd15);
        chk("flush_busy", {31'd0, busy}, 32'd0);
        chk("flush_done", {31'd0, done}, 32'd0);
        chk("flush_hi", hi, 32'h1111_1111);
        chk("flush_lo", lo, 32'hFFFF_FFFF);
        for (int i = 0; i < 25; i++) begin
            if (done === 1'b1) chk("flush_late_done", {31'd0, done}, 32'd0);
            tick();
        end
        chk("flush_hi_after", hi, 32'h1111_1111);

        // both moves together
        mthi = 1'b1; mtlo = 1'b1; wdata = 32'hABCD_0123;
        tick();
        mthi = 1'b0; mtlo = 1'b0;
        chk("mv_both_hi", hi, 32'hABCD_0123);
        chk("mv_both_lo", lo, 32'hABCD_0123);

        // start with flush in IDLE is discarded, and the move with it dropped
        start = 1'b1; flush = 1'b1; mthi = 1'b1; wdata = 32'h5555_5555;
        op = 2'b01; rs_val = 32'd2; rt_val = 32'd3;
        tick();
        start = 1'b0; flush = 1'b0; mthi = 1'b0;
        chk("idle_flush_busy", {31'd0, busy}, 32'd0);
        chk("idle_flush_hi", hi, 32'hABCD_0123);

        // start wins over a simultaneous move
        mtlo = 1'b1; wdata = 32'h7777_7777;
        start = 1'b1; op = 2'b01; rs_val = 32'd2; rt_val = 32'd3;
        tick();
        start = 1'b0; mtlo = 1'b0;
        chk("start_mv_lo", lo, 32'hABCD_0123);
        chk("start_mv_busy", {31'd0, busy}, 32'd1);
        bc = 0;
        while (busy === 1'b1 && bc < 100) begin bc++; tick(); end
        chk("start_mv_cycles", bc, 32'd33);
        chk("start_mv_res_lo", lo, 32'd6);
        chk("start_mv_res_hi", hi, 32'd0);

        // reset mid-op
        start = 1'b1; op = 2'b01; rs_val = 32'd5; rt_val = 32'd5;
        tick();
        start = 1'b0;
        bc = 0;
        while (busy === 1'b1 && bc < 20) begin
            bc++;
            if (bc == 20) rst = 1'b1;
            tick();
        end
        rst = 1'b0;
        chk("rst_mid_reached", bc, 32'd20);
        chk("rst_mid_hi", hi, 32'h0);
        chk("rst_mid_lo", lo, 32'h0);
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_done", {31'd0, done}, 32'd0);
        run_op("multu_5x5", 2'b01, 32'd5, 32'd5, 32'h0, 32'h0, 32'h0, 32'd25, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
